// File: rtl/ex_stage_pkg.sv
// rtl/ex_stage_pkg.sv - shared widths, bus layouts and one-hot field indices for the EX stage
package ex_stage_pkg;

    localparam int ID_TO_EX_WD  = 167;
    localparam int EX_TO_MEM_WD = 76;
    localparam int EX_TO_ID_WD  = 38;
    localparam int STALL_WD     = 6;
    localparam int DIV_CYCLES   = 32;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam int ALU_ADD  = 11;
    localparam int ALU_SUB  = 10;
    localparam int ALU_SLT  = 9;
    localparam int ALU_SLTU = 8;
    localparam int ALU_AND  = 7;
    localparam int ALU_NOR  = 6;
    localparam int ALU_OR   = 5;
    localparam int ALU_XOR  = 4;
    localparam int ALU_SLL  = 3;
    localparam int ALU_SRL  = 2;
    localparam int ALU_SRA  = 1;
    localparam int ALU_LUI  = 0;

    localparam int MD_DIV   = 7;
    localparam int MD_DIVU  = 6;
    localparam int MD_MULT  = 5;
    localparam int MD_MULTU = 4;
    localparam int MD_MFHI  = 3;
    localparam int MD_MFLO  = 2;
    localparam int MD_MTHI  = 1;
    localparam int MD_MTLO  = 0;

    localparam int SRC1_RS   = 2;
    localparam int SRC1_PC   = 1;
    localparam int SRC1_SA   = 0;
    localparam int SRC2_RT   = 3;
    localparam int SRC2_SIMM = 2;
    localparam int SRC2_ZIMM = 1;
    localparam int SRC2_C8   = 0;

    localparam logic [3:0] WEN_BYTE = 4'b0001;
    localparam logic [3:0] WEN_HALF = 4'b0011;
    localparam logic [3:0] WEN_WORD = 4'b1111;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [11:0] alu_op;
        logic [2:0]  sel_src1;
        logic [3:0]  sel_src2;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        sel_rf_res;
        logic [7:0]  md_op;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
    } id_ex_t;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BUSY,
        DIV_DONE
    } div_state_t;

endpackage

// File: rtl/ex_stage_div_radix2.sv
// rtl/ex_stage_div_radix2.sv - iterative restoring divider, one quotient bit per cycle
module div_radix2
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_op,
    input  logic        release_done,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] quo,
    output logic [31:0] rem
);

    div_state_t  state;
    logic [4:0]  cnt;
    logic [31:0] q_r;
    logic [31:0] r_r;
    logic [31:0] d_r;
    logic        neg_q;
    logic        neg_r;

    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [32:0] trial;
    logic [31:0] q_nx;
    logic [31:0] r_nx;
    logic        last;
    logic        zero_div;

    assign a_abs = (signed_op && a[31]) ? -a : a;
    assign b_abs = (signed_op && b[31]) ? -b : b;

    // Borrow out of the 33-bit trial subtract means the partial remainder is restored.
    assign trial = {r_r, q_r[31]} - {1'b0, d_r};
    assign q_nx  = {q_r[30:0], ~trial[32]};
    assign r_nx  = trial[32] ? {r_r[30:0], q_r[31]} : trial[31:0];

    assign last     = (state == DIV_BUSY) && (cnt == 5'(DIV_CYCLES - 1));
    assign zero_div = (state == DIV_IDLE) && start && (b == 32'd0);

    assign busy = (state == DIV_BUSY) || ((state == DIV_IDLE) && start);
    assign done = last || zero_div;
    assign quo  = zero_div ? 32'hFFFF_FFFF : (neg_q ? -q_nx : q_nx);
    assign rem  = zero_div ? a : (neg_r ? -r_nx : r_nx);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= DIV_IDLE;
            cnt   <= 5'd0;
            q_r   <= 32'd0;
            r_r   <= 32'd0;
            d_r   <= 32'd0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        if (b == 32'd0) begin
                            state <= DIV_DONE;
                        end else begin
                            state <= DIV_BUSY;
                            cnt   <= 5'd0;
                            q_r   <= a_abs;
                            r_r   <= 32'd0;
                            d_r   <= b_abs;
                            neg_q <= signed_op && (a[31] ^ b[31]);
                            neg_r <= signed_op && a[31];
                        end
                    end
                end
                DIV_BUSY: begin
                    q_r <= q_nx;
                    r_r <= r_nx;
                    cnt <= cnt + 5'd1;
                    if (last) state <= DIV_DONE;
                end
                DIV_DONE: begin
                    // Held here until EX moves on so the same div is not issued twice.
                    if (release_done) state <= DIV_IDLE;
                end
                default: state <= DIV_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS execute stage: ALU, store alignment, HI/LO with mult and iterative div
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic [EX_TO_ID_WD-1:0]  ex_to_id_bus,
    output logic                    stallreq_for_ex,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata
);

    id_ex_t ex_r;
    logic   adv;
    logic   bubble;

    assign adv    = (stall[2] == NO_STOP);
    assign bubble = (stall[2] == STOP) && (stall[3] == NO_STOP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        ex_r <= '0;
        else if (bubble) ex_r <= '0;
        else if (adv)    ex_r <= id_ex_t'(id_to_ex_bus);
    end

    logic [31:0] imm_s;
    logic [31:0] imm_z;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] sum;
    logic [31:0] alu_res;
    logic [4:0]  sa;

    assign imm_s = {{16{ex_r.inst[15]}}, ex_r.inst[15:0]};
    assign imm_z = {16'd0, ex_r.inst[15:0]};

    assign src1 = ({32{ex_r.sel_src1[SRC1_RS]}} & ex_r.rdata1)
                | ({32{ex_r.sel_src1[SRC1_PC]}} & ex_r.pc)
                | ({32{ex_r.sel_src1[SRC1_SA]}} & {27'd0, ex_r.inst[10:6]});
    assign src2 = ({32{ex_r.sel_src2[SRC2_RT]}}   & ex_r.rdata2)
                | ({32{ex_r.sel_src2[SRC2_SIMM]}} & imm_s)
                | ({32{ex_r.sel_src2[SRC2_ZIMM]}} & imm_z)
                | ({32{ex_r.sel_src2[SRC2_C8]}}   & 32'd8);

    assign sum = src1 + src2;
    assign sa  = src1[4:0];

    always_comb begin
        alu_res = 32'd0;
        if (ex_r.alu_op[ALU_ADD])  alu_res = alu_res | sum;
        if (ex_r.alu_op[ALU_SUB])  alu_res = alu_res | (src1 - src2);
        if (ex_r.alu_op[ALU_SLT])  alu_res = alu_res | {31'd0, $signed(src1) < $signed(src2)};
        if (ex_r.alu_op[ALU_SLTU]) alu_res = alu_res | {31'd0, src1 < src2};
        if (ex_r.alu_op[ALU_AND])  alu_res = alu_res | (src1 & src2);
        if (ex_r.alu_op[ALU_NOR])  alu_res = alu_res | ~(src1 | src2);
        if (ex_r.alu_op[ALU_OR])   alu_res = alu_res | (src1 | src2);
        if (ex_r.alu_op[ALU_XOR])  alu_res = alu_res | (src1 ^ src2);
        if (ex_r.alu_op[ALU_SLL])  alu_res = alu_res | (src2 << sa);
        if (ex_r.alu_op[ALU_SRL])  alu_res = alu_res | (src2 >> sa);
        if (ex_r.alu_op[ALU_SRA])  alu_res = alu_res | 32'($signed(src2) >>> sa);
        if (ex_r.alu_op[ALU_LUI])  alu_res = alu_res | {src2[15:0], 16'd0};
    end

    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] ex_result;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_start;
    logic        div_busy;
    logic        div_done;
    logic [31:0] div_quo;
    logic [31:0] div_rem;

    assign prod_s = 64'($signed({{32{ex_r.rdata1[31]}}, ex_r.rdata1}) * $signed({{32{ex_r.rdata2[31]}}, ex_r.rdata2}));
    assign prod_u = {32'd0, ex_r.rdata1} * {32'd0, ex_r.rdata2};

    assign div_start = ex_r.md_op[MD_DIV] | ex_r.md_op[MD_DIVU];

    div_radix2 u_div (
        .clk          (clk),
        .rst          (rst),
        .start        (div_start),
        .signed_op    (ex_r.md_op[MD_DIV]),
        .release_done (adv | bubble),
        .a            (ex_r.rdata1),
        .b            (ex_r.rdata2),
        .busy         (div_busy),
        .done         (div_done),
        .quo          (div_quo),
        .rem          (div_rem)
    );

    // Divider results land while EX is stalled; all other HI/LO writers commit only as EX advances.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (div_done) begin
            hi <= div_rem;
            lo <= div_quo;
        end else if (adv) begin
            if (ex_r.md_op[MD_MULT])  {hi, lo} <= prod_s;
            if (ex_r.md_op[MD_MULTU]) {hi, lo} <= prod_u;
            if (ex_r.md_op[MD_MTHI])  hi <= ex_r.rdata1;
            if (ex_r.md_op[MD_MTLO])  lo <= ex_r.rdata1;
        end
    end

    assign stallreq_for_ex = div_start & div_busy;

    assign ex_result = ex_r.md_op[MD_MFHI] ? hi :
                       ex_r.md_op[MD_MFLO] ? lo : alu_res;

    logic wen_ok;

    always_comb begin
        wen_ok = 1'b1;
        if (ex_r.ram_wen == WEN_HALF && sum[0])          wen_ok = 1'b0;
        if (ex_r.ram_wen == WEN_WORD && sum[1:0] != 2'b0) wen_ok = 1'b0;
        data_sram_wen = wen_ok ? (ex_r.ram_wen << sum[1:0]) : 4'b0000;
        case (ex_r.ram_wen)
            WEN_BYTE: data_sram_wdata = {4{ex_r.rdata2[7:0]}};
            WEN_HALF: data_sram_wdata = {2{ex_r.rdata2[15:0]}};
            default:  data_sram_wdata = ex_r.rdata2;
        endcase
    end

    assign data_sram_en   = ex_r.ram_en;
    assign data_sram_addr = sum;

    assign ex_to_mem_bus = {ex_r.pc, ex_r.ram_en, ex_r.ram_wen, ex_r.sel_rf_res,
                            ex_r.rf_we, ex_r.rf_waddr, ex_result};
    assign ex_to_id_bus  = {ex_r.rf_we, ex_r.rf_waddr, ex_result};

    logic unused_bits;
    assign unused_bits = ^{ex_r.inst[31:16], stall[5:4], stall[1:0]};

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - directed self-checking bench for ex_stage
module tb_ex_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   stall;
    logic [166:0] bus;
    logic [75:0]  ex_to_mem_bus;
    logic [37:0]  ex_to_id_bus;
    logic         stallreq;
    logic         sram_en;
    logic [3:0]   sram_wen;
    logic [31:0]  sram_addr;
    logic [31:0]  sram_wdata;

    int checks   = 0;
    int failures = 0;
    int n;

    localparam logic [11:0] A_ADD = 12'h800, A_SLT = 12'h200, A_SLTU = 12'h100;
    localparam logic [11:0] A_SRA = 12'h002, A_LUI = 12'h001, A_NONE = 12'h000;
    localparam logic [7:0]  M_DIV = 8'h80, M_DIVU = 8'h40, M_MULT = 8'h20, M_MULTU = 8'h10;
    localparam logic [7:0]  M_MFHI = 8'h08, M_MFLO = 8'h04, M_MTHI = 8'h02, M_NONE = 8'h00;
    localparam logic [2:0]  S1_RS = 3'b100, S1_SA = 3'b001, S1_NONE = 3'b000;
    localparam logic [3:0]  S2_RT = 4'b1000, S2_SIMM = 4'b0100, S2_ZIMM = 4'b0010, S2_NONE = 4'b0000;
    localparam logic [5:0]  ST_RUN = 6'b000000, ST_HOLD = 6'b001111, ST_BUBBLE = 6'b000100;

    ex_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .id_to_ex_bus    (bus),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .ex_to_id_bus    (ex_to_id_bus),
        .stallreq_for_ex (stallreq),
        .data_sram_en    (sram_en),
        .data_sram_wen   (sram_wen),
        .data_sram_addr  (sram_addr),
        .data_sram_wdata (sram_wdata)
    );

    always #5 clk = ~clk;

    function automatic logic [166:0] mk(input logic [31:0] pc, input logic [31:0] inst,
                                        input logic [11:0] alu, input logic [2:0] s1,
                                        input logic [3:0] s2, input logic en, input logic [3:0] wen,
                                        input logic we, input logic [4:0] wa, input logic [7:0] md,
                                        input logic [31:0] r1, input logic [31:0] r2);
        return {pc, inst, alu, s1, s2, en, wen, we, wa, 1'b0, md, r1, r2};
    endfunction

    function automatic logic [166:0] alu_rr(input logic [11:0] alu, input logic [31:0] r1, input logic [31:0] r2);
        return mk(32'hBFC0_0100, 32'd0, alu, S1_RS, S2_RT, 1'b0, 4'd0, 1'b1, 5'd3, M_NONE, r1, r2);
    endfunction

    function automatic logic [166:0] md_ins(input logic [7:0] md, input logic [31:0] r1, input logic [31:0] r2);
        return mk(32'hBFC0_0200, 32'd0, A_NONE, S1_NONE, S2_NONE, 1'b0, 4'd0,
                  (md == M_MFHI) || (md == M_MFLO), 5'd4, md, r1, r2);
    endfunction

    function automatic logic [166:0] store(input logic [3:0] code, input logic [31:0] base,
                                           input logic [15:0] off, input logic [31:0] rt);
        return mk(32'hBFC0_0300, {16'd0, off}, A_ADD, S1_RS, S2_SIMM, 1'b1, code, 1'b0, 5'd0, M_NONE, base, rt);
    endfunction

    task automatic chk(input string tag, input logic [75:0] obs, input logic [75:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [166:0] v, input logic [5:0] s);
        @(negedge clk);
        bus   = v;
        stall = s;
        @(posedge clk);
        #1;
    endtask

    task automatic count_stall(output int cnt);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stallreq) break;
            cnt++;
            stall = ST_HOLD;
        end
    endtask

    initial begin
        rst   = 1'b0;
        stall = ST_RUN;
        bus   = alu_rr(A_ADD, 32'd1, 32'd2);
        repeat (2) @(posedge clk);
        #3;
        chk("reset_mem_bus", ex_to_mem_bus, 76'd0);
        chk("reset_id_bus", ex_to_id_bus, 76'd0);
        chk("reset_stallreq", stallreq, 76'd0);
        chk("reset_sram", {sram_en, sram_wen, sram_addr, sram_wdata}, 76'd0);
        @(negedge clk);
        rst = 1'b1;

        issue(md_ins(M_MFHI, 0, 0), ST_RUN);
        chk("reset_hi", ex_to_id_bus[31:0], 76'd0);
        issue(md_ins(M_MFLO, 0, 0), ST_RUN);
        chk("reset_lo", ex_to_id_bus[31:0], 76'd0);

        issue(alu_rr(A_ADD, 32'h7FFF_FFFF, 32'd1), ST_RUN);
        chk("add_wrap", ex_to_id_bus, {38'd0, 1'b1, 5'd3, 32'h8000_0000});
        chk("add_mem_bus", ex_to_mem_bus, {32'hBFC0_0100, 1'b0, 4'd0, 1'b0, 1'b1, 5'd3, 32'h8000_0000});
        issue(alu_rr(A_SLT, 32'hFFFF_FFFF, 32'd1), ST_RUN);
        chk("slt", ex_to_id_bus[31:0], 76'd1);
        issue(alu_rr(A_SLTU, 32'hFFFF_FFFF, 32'd1), ST_RUN);
        chk("sltu", ex_to_id_bus[31:0], 76'd0);
        issue(mk(32'd0, 32'h0000_0100, A_SRA, S1_SA, S2_RT, 1'b0, 4'd0, 1'b1, 5'd3, M_NONE, 32'd0, 32'h8000_0000), ST_RUN);
        chk("sra", ex_to_id_bus[31:0], 76'hF800_0000);
        issue(mk(32'd0, 32'h0000_1234, A_LUI, S1_NONE, S2_ZIMM, 1'b0, 4'd0, 1'b1, 5'd3, M_NONE, 32'd0, 32'd0), ST_RUN);
        chk("lui", ex_to_id_bus[31:0], 76'h1234_0000);

        issue(store(4'b0001, 32'h1000, 16'h0003, 32'h0000_00AB), ST_RUN);
        chk("sb_sram", {sram_en, sram_wen, sram_addr, sram_wdata}, {1'b1, 4'b1000, 32'h0000_1003, 32'hABAB_ABAB});
        chk("sb_mem_bus", ex_to_mem_bus, {32'hBFC0_0300, 1'b1, 4'b0001, 1'b0, 1'b0, 5'd0, 32'h0000_1003});
        issue(store(4'b0011, 32'h1000, 16'h0001, 32'h0000_BEEF), ST_RUN);
        chk("sh_misaligned", {sram_en, sram_wen}, {71'd0, 1'b1, 4'b0000});
        issue(store(4'b0011, 32'h1000, 16'h0002, 32'h0000_BEEF), ST_RUN);
        chk("sh_upper", {sram_en, sram_wen, sram_wdata}, {39'd0, 1'b1, 4'b1100, 32'hBEEF_BEEF});
        issue(store(4'b1111, 32'h1000, 16'h0004, 32'h1234_5678), ST_RUN);
        chk("sw", {sram_en, sram_wen, sram_wdata}, {39'd0, 1'b1, 4'b1111, 32'h1234_5678});
        issue(store(4'b1111, 32'h1000, 16'h0002, 32'h1234_5678), ST_RUN);
        chk("sw_misaligned", {sram_en, sram_wen}, {71'd0, 1'b1, 4'b0000});

        issue(md_ins(M_MULT, 32'hFFFF_FFFE, 32'd3), ST_RUN);
        issue(md_ins(M_MFHI, 0, 0), ST_RUN);
        chk("mult_hi", ex_to_id_bus[31:0], 76'hFFFF_FFFF);
        issue(md_ins(M_MFLO, 0, 0), ST_RUN);
        chk("mult_lo", ex_to_id_bus[31:0], 76'hFFFF_FFFA);
        issue(md_ins(M_MULTU, 32'hFFFF_FFFE, 32'd3), ST_RUN);
        issue(md_ins(M_MFHI, 0, 0), ST_RUN);
        chk("multu_hi", ex_to_id_bus[31:0], 76'h2);
        issue(md_ins(M_MTHI, 32'hCAFE_BABE, 0), ST_RUN);
        issue(md_ins(M_MFHI, 0, 0), ST_RUN);
        chk("mthi", ex_to_id_bus[31:0], 76'hCAFE_BABE);

        issue(md_ins(M_DIV, 32'hFFFF_FFF9, 32'd2), ST_RUN);
        count_stall(n);
        chk("div_stall_cycles", n, 76'd33);
        issue(md_ins(M_MFLO, 0, 0), ST_RUN);
        chk("div_lo", ex_to_id_bus[31:0], 76'hFFFF_FFFD);
        chk("div_no_restall", stallreq, 76'd0);
        issue(md_ins(M_MFHI, 0, 0), ST_RUN);
        chk("div_hi", ex_to_id_bus[31:0], 76'hFFFF_FFFF);

        issue(md_ins(M_DIVU, 32'h1234_5678, 32'd0), ST_RUN);
        count_stall(n);
        chk("divz_stall_cycles", n, 76'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            stall = ST_HOLD;
            #1;
            chk("divz_hold_no_restart", stallreq, 76'd0);
        end
        issue(md_ins(M_MFLO, 0, 0), ST_RUN);
        chk("divz_lo", ex_to_id_bus[31:0], 76'hFFFF_FFFF);
        issue(md_ins(M_MFHI, 0, 0), ST_RUN);
        chk("divz_hi", ex_to_id_bus[31:0], 76'h1234_5678);

        issue(alu_rr(A_ADD, 32'd5, 32'd6), ST_RUN);
        issue(alu_rr(A_ADD, 32'd50, 32'd60), 6'b001100);
        chk("hold_keeps_ex", ex_to_id_bus[31:0], 76'd11);
        issue(alu_rr(A_ADD, 32'd50, 32'd60), ST_BUBBLE);
        chk("bubble_mem_bus", ex_to_mem_bus, 76'd0);

        issue(md_ins(M_DIV, 32'd100, 32'd7), ST_RUN);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            stall = ST_HOLD;
        end
        #2;
        rst = 1'b0;
        #1;
        chk("abort_stallreq", stallreq, 76'd0);
        chk("abort_mem_bus", ex_to_mem_bus, 76'd0);
        @(negedge clk);
        rst = 1'b1;
        issue(md_ins(M_MFLO, 0, 0), ST_RUN);
        chk("abort_lo", ex_to_id_bus[31:0], 76'd0);
        chk("abort_idle", stallreq, 76'd0);
        issue(md_ins(M_MFHI, 0, 0), ST_RUN);
        chk("abort_hi", ex_to_id_bus[31:0], 76'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
